// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_if
//  Description : Control/status bundle between the fetch-address generator
//                and the pipeline/instruction-memory logic around it.
//                slave  : the PC generator (consumes controls, drives PC).
//                master : the surrounding core / testbench.
//  Ports       : stall, halt_req, trap_en/trap_addr, redirect_en/
//                redirect_addr, inst_is_c, fetch_ready  (master -> slave)
//                pc_out, pc_plus, fetch_valid, misalign_err, bad_addr
//                                                       (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            halt_req;
    logic            trap_en;
    logic [XLEN-1:0] trap_addr;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_addr;
    logic            inst_is_c;
    logic            fetch_ready;

    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus;
    logic            fetch_valid;
    logic            misalign_err;
    logic [XLEN-1:0] bad_addr;

    modport master (
        output stall, halt_req, trap_en, trap_addr, redirect_en,
               redirect_addr, inst_is_c, fetch_ready,
        input  pc_out, pc_plus, fetch_valid, misalign_err, bad_addr
    );

    modport slave (
        input  stall, halt_req, trap_en, trap_addr, redirect_en,
               redirect_addr, inst_is_c, fetch_ready,
        output pc_out, pc_plus, fetch_valid, misalign_err, bad_addr
    );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Program-counter generator. Holds the fetch address and
//                selects the next one each cycle from trap vector, branch/
//                jump target, sequential advance or hold. Three states:
//                BOOT (one idle cycle after reset), RUN (fetching) and
//                HALT (fetch suspended). Misaligned redirect targets are
//                rejected and reported.
//  Ports       : clk, rst (sync, active-high)
//                bus : pc_gen_if.slave (see interface header)
//  Parameters  : XLEN       address width
//                RESET_ADDR PC value after reset
//                IALIGN     16 (compressed, +2 stepping) or 32
//  Revision    : 1.0  initial release
// ============================================================================
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int              IALIGN     = 32
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [XLEN-1:0] c_align_mask = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_misalign_err;
    logic [XLEN-1:0] r_bad_addr;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_pc_adv;
    logic [XLEN-1:0] w_trap_pc;
    logic            w_misaligned;
    logic            w_reject;
    logic            w_fetch_valid;

    // Step size: only an IALIGN=16 build honours the compressed flag.
    generate
        if (IALIGN == 16) begin : g_step_c
            assign w_step = bus.inst_is_c ? XLEN'(2) : XLEN'(4);
        end else begin : g_step_fixed
            assign w_step = XLEN'(4);
        end
    endgenerate

    // Natural modulo-2^XLEN wrap: no carry-out is kept or reported.
    assign w_pc_adv     = r_pc + w_step;
    assign w_trap_pc    = bus.trap_addr & ~c_align_mask;
    assign w_misaligned = |(bus.redirect_addr & c_align_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_ADDR;
            r_misalign_err <= 1'b0;
            r_bad_addr     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            // Pulse lasts exactly the cycle after the rejected redirect.
            r_misalign_err <= w_reject;
            if (w_reject) begin
                r_bad_addr <= bus.redirect_addr;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_reject      = 1'b0;
        w_fetch_valid = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end

            ST_RUN: begin
                w_fetch_valid = 1'b1;
                if (bus.trap_en) begin
                    w_pc_nxt = w_trap_pc;
                end else if (bus.redirect_en) begin
                    // Redirects bypass stall and fetch_ready entirely.
                    if (w_misaligned) begin
                        w_reject = 1'b1;
                    end else begin
                        w_pc_nxt = bus.redirect_addr;
                    end
                end else if (bus.halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (!bus.stall && bus.fetch_ready) begin
                    w_pc_nxt = w_pc_adv;
                end
            end

            ST_HALT: begin
                // stall has no effect while halted.
                if (bus.trap_en) begin
                    w_pc_nxt    = w_trap_pc;
                    w_state_nxt = ST_RUN;
                end else if (bus.redirect_en) begin
                    // A rejected target keeps the core halted.
                    if (w_misaligned) begin
                        w_reject = 1'b1;
                    end else begin
                        w_pc_nxt    = bus.redirect_addr;
                        w_state_nxt = ST_RUN;
                    end
                end else if (!bus.halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign bus.pc_out       = r_pc;
    assign bus.pc_plus      = w_pc_adv;
    assign bus.fetch_valid  = w_fetch_valid;
    assign bus.misalign_err = r_misalign_err;
    assign bus.bad_addr     = r_bad_addr;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen. Two instances (IALIGN=32
//                and IALIGN=16) see identical stimulus; each is compared
//                every cycle against a behavioural model, with directed
//                scenarios followed by randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_gen;

    logic clk;
    logic rst;

    logic        stall, halt_req, trap_en, redirect_en, inst_is_c, fetch_ready;
    logic [31:0] trap_addr, redirect_addr;

    int n_vec;
    int n_err;

    pc_gen_if #(.XLEN(32)) bus32 ();
    pc_gen_if #(.XLEN(32)) bus16 ();

    pc_gen #(.XLEN(32), .RESET_ADDR(32'h0000_0000), .IALIGN(32)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    pc_gen #(.XLEN(32), .RESET_ADDR(32'h0000_0000), .IALIGN(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: index 0 -> IALIGN=32, index 1 -> IALIGN=16.
    // mode: 0 = booting, 1 = fetching, 2 = halted.
    logic [31:0] m_pc   [2];
    int          m_mode [2];
    logic        m_err  [2];
    logic [31:0] m_bad  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input int k);
        return (k == 1 && inst_is_c) ? 32'd2 : 32'd4;
    endfunction

    function automatic logic [31:0] model_mask(input int k);
        return (k == 1) ? 32'd1 : 32'd3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_mode[k] = 0; m_err[k] = 1'b0; m_bad[k] = 32'h0;
        end
    endtask

    task automatic model_update();
        bit ok_target;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            ok_target = ((redirect_addr % (model_mask(k) + 1)) == 0);
            m_err[k]  = 1'b0;
            if (m_mode[k] == 0) begin
                m_mode[k] = 1;
            end else if (trap_en) begin
                m_pc[k]   = trap_addr - (trap_addr % (model_mask(k) + 1));
                m_mode[k] = 1;
            end else if (redirect_en && !ok_target) begin
                m_err[k] = 1'b1;
                m_bad[k] = redirect_addr;
            end else if (redirect_en) begin
                m_pc[k]   = redirect_addr;
                m_mode[k] = 1;
            end else if (m_mode[k] == 2) begin
                if (!halt_req) m_mode[k] = 1;
            end else if (halt_req) begin
                m_mode[k] = 2;
            end else if (!stall && fetch_ready) begin
                m_pc[k] = m_pc[k] + model_step(k);
            end
        end
    endtask

    task automatic check_models();
        chk("pc32",    bus32.pc_out,              m_pc[0]);
        chk("plus32",  bus32.pc_plus,             m_pc[0] + model_step(0));
        chk("fv32",    32'(bus32.fetch_valid),    32'(m_mode[0] == 1));
        chk("err32",   32'(bus32.misalign_err),   32'(m_err[0]));
        chk("bad32",   bus32.bad_addr,            m_bad[0]);
        chk("pc16",    bus16.pc_out,              m_pc[1]);
        chk("plus16",  bus16.pc_plus,             m_pc[1] + model_step(1));
        chk("fv16",    32'(bus16.fetch_valid),    32'(m_mode[1] == 1));
        chk("err16",   32'(bus16.misalign_err),   32'(m_err[1]));
        chk("bad16",   bus16.bad_addr,            m_bad[1]);
    endtask

    task automatic drive_buses();
        bus32.stall = stall;         bus16.stall = stall;
        bus32.halt_req = halt_req;   bus16.halt_req = halt_req;
        bus32.trap_en = trap_en;     bus16.trap_en = trap_en;
        bus32.trap_addr = trap_addr; bus16.trap_addr = trap_addr;
        bus32.redirect_en = redirect_en;     bus16.redirect_en = redirect_en;
        bus32.redirect_addr = redirect_addr; bus16.redirect_addr = redirect_addr;
        bus32.inst_is_c = inst_is_c;     bus16.inst_is_c = inst_is_c;
        bus32.fetch_ready = fetch_ready; bus16.fetch_ready = fetch_ready;
    endtask

    // Called just after a falling edge with the next inputs already set:
    // compare, advance the model, clock once, return after the next fall.
    task automatic tick();
        drive_buses();
        #1;
        check_models();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; halt_req = 0; trap_en = 0; redirect_en = 0;
        inst_is_c = 0; fetch_ready = 0; trap_addr = 0; redirect_addr = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        idle_inputs();
        fetch_ready = 1'b1;
        drive_buses();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state
        chk("rst_pc",  bus32.pc_out, 32'h0);
        chk("rst_fv",  32'(bus32.fetch_valid), 32'h0);
        chk("rst_err", 32'(bus32.misalign_err), 32'h0);
        chk("rst_bad", bus32.bad_addr, 32'h0);

        // Release: one BOOT cycle, then sequential fetch 0,4,8,C
        rst = 1'b0;
        drive_buses();
        #1;
        chk("boot_fv", 32'(bus32.fetch_valid), 32'h0);
        chk("boot_pc", bus32.pc_out, 32'h0);
        tick();
        chk("seq0_fv", 32'(bus32.fetch_valid), 32'h1);
        chk("seq0", bus32.pc_out, 32'h0);
        tick(); chk("seq4", bus32.pc_out, 32'h4);
        tick(); chk("seq8", bus32.pc_out, 32'h8);
        tick(); chk("seqC", bus32.pc_out, 32'hC);

        // Redirect wins over a simultaneous stall
        redirect_en = 1; redirect_addr = 32'h100; tick();
        chk("redir_100", bus32.pc_out, 32'h100);
        stall = 1; redirect_addr = 32'h200; tick();
        chk("stall_redir", bus32.pc_out, 32'h200);
        redirect_en = 0; tick();
        chk("stall_hold", bus32.pc_out, 32'h200);
        stall = 0;

        // Trap beats redirect, low bits cleared, no error
        trap_en = 1; trap_addr = 32'h803; redirect_en = 1; redirect_addr = 32'h400; tick();
        chk("trap32", bus32.pc_out, 32'h800);
        chk("trap16", bus16.pc_out, 32'h802);
        chk("trap_err", 32'(bus32.misalign_err), 32'h0);
        trap_en = 0;

        // Half-word target: rejected at IALIGN=32, accepted at 16
        redirect_addr = 32'h102; tick();
        chk("mis_pc32", bus32.pc_out, 32'h800);
        chk("mis_err", 32'(bus32.misalign_err), 32'h1);
        chk("mis_bad", bus32.bad_addr, 32'h102);
        chk("mis_pc16", bus16.pc_out, 32'h102);
        redirect_en = 0; fetch_ready = 0; tick();
        chk("mis_pulse", 32'(bus32.misalign_err), 32'h0);
        chk("mis_bad_keep", bus32.bad_addr, 32'h102);

        // Compressed stepping and address wrap
        redirect_en = 1; redirect_addr = 32'h10; tick();
        redirect_en = 0; fetch_ready = 1; inst_is_c = 1; tick();
        chk("c_step", bus16.pc_out, 32'h12);
        inst_is_c = 0; tick();
        chk("nc_step", bus16.pc_out, 32'h16);
        redirect_en = 1; redirect_addr = 32'hFFFF_FFFC; tick();
        redirect_en = 0; tick();
        chk("wrap", bus32.pc_out, 32'h0);

        // Halt, resume, reset during halt
        redirect_en = 1; redirect_addr = 32'h40; tick();
        redirect_en = 0; halt_req = 1; tick();
        chk("halt_fv", 32'(bus32.fetch_valid), 32'h0);
        chk("halt_pc", bus32.pc_out, 32'h40);
        stall = 1; tick();
        chk("halt_hold", bus32.pc_out, 32'h40);
        stall = 0; halt_req = 0; tick();
        chk("resume_fv", 32'(bus32.fetch_valid), 32'h1);
        tick();
        chk("resume_adv", bus32.pc_out, 32'h44);
        halt_req = 1; tick();
        rst = 1; trap_en = 1; trap_addr = 32'h900; tick();
        chk("halt_rst_pc", bus32.pc_out, 32'h0);
        chk("halt_rst_fv", 32'(bus32.fetch_valid), 32'h0);
        rst = 0; idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            rst         = ($urandom_range(0, 99) == 0);
            trap_en     = ($urandom_range(0, 15) == 0);
            redirect_en = ($urandom_range(0, 7) == 0);
            halt_req    = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            inst_is_c   = 1'($urandom_range(0, 1));
            trap_addr   = $urandom;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31:8] = 24'hFFFFFF;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            redirect_addr = a;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of every address port and the PC register.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000, value loaded into the PC on reset.
REQ-003 Parameter IALIGN, default 32, instruction alignment in bits (legal values 16 or 32); 16 enables compressed (+2) stepping.
REQ-004 clk  input  1  Single clock; all state updates on rising edge.
REQ-005 rst  input  1  Reset, synchronous and active-high.
REQ-006 stall  input  1  Hold PC (e.g. load awaiting data memory).
REQ-007 halt_req  input  1  Request to stop fetching (debug/WFI).
REQ-008 trap_en  input  1  Take trap this cycle.
REQ-009 trap_addr  input  XLEN  Trap vector.
REQ-010 redirect_en  input  1  Branch taken or jump.
REQ-011 redirect_addr  input  XLEN  Branch/jump target.
REQ-012 inst_is_c  input  1  Current instruction is compressed; used only when IALIGN=16.
REQ-013 fetch_ready  input  1  Instruction memory accepts pc_out this cycle.
REQ-014 pc_out  output  XLEN  Current fetch address (registered).
REQ-015 pc_plus  output  XLEN  pc_out + step (combinational, for link register).
REQ-016 fetch_valid  output  1  pc_out is a valid fetch request.
REQ-017 misalign_err  output  1  One-cycle pulse: rejected misaligned redirect.
REQ-018 bad_addr  output  XLEN  Last rejected redirect target (registered).

Function
REQ-019 State machine states BOOT, RUN, HALT; state encoding is internal.
REQ-020 step = 2 when IALIGN=16 and inst_is_c=1, else 4.
REQ-021 All PC arithmetic is modulo 2^XLEN; all-ones-region increment wraps to low addresses without flag.
REQ-022 BOOT: fetch_valid=0, PC held; unconditionally RUN on next cycle (exactly one BOOT cycle after rst deasserts).
REQ-023 RUN, fetch_valid=1; next-PC priority per cycle: trap_en > redirect_en > halt_req > stall > advance > hold.
REQ-024 trap_en: PC <= trap_addr with low alignment bits forced to 0 (bits[1:0] for IALIGN=32, bit[0] for 16); never raises misalign_err.
REQ-025 redirect_en with aligned target: PC <= redirect_addr next cycle, independent of stall and fetch_ready.
REQ-026 redirect_en with misaligned target: PC held, misalign_err=1 next cycle for exactly one cycle, bad_addr <= redirect_addr.
REQ-027 halt_req (no trap/redirect): state <= HALT, PC held.
REQ-028 advance: PC <= PC + step only when fetch_valid & fetch_ready & !stall; stall or !fetch_ready holds PC.
REQ-029 HALT: fetch_valid=0; trap_en -> RUN with trap PC; aligned redirect_en -> RUN with target; halt_req=0 -> RUN with PC unchanged; otherwise remain; stall ignored.
REQ-030 misalign_err is 0 in every cycle not directly following a rejected redirect; bad_addr changes only on rejection or reset.
REQ-031 pc_plus valid in every state, derived from pc_out and current inst_is_c.

Reset
REQ-032 rst=1 at a clock edge: pc_out=RESET_ADDR, state=BOOT, fetch_valid=0, misalign_err=0, bad_addr=0.
REQ-033 rst overrides all other inputs, including mid-HALT and coincident trap/redirect; any pending behaviour discarded.

Verification
REQ-034 Reset release, fetch_ready=1, no events -> cycle 1 fetch_valid=0 pc_out=0; then pc_out 0,4,8,C on successive cycles.
REQ-035 pc_out=0x100, stall=1 and redirect_en=1 redirect_addr=0x200 same cycle -> next pc_out=0x200; stall alone next cycle holds 0x200.
REQ-036 trap_en=1 trap_addr=0x803, redirect_en=1 redirect_addr=0x400 same cycle -> pc_out=0x800, misalign_err stays 0.
REQ-037 redirect_addr=0x102, IALIGN=32 -> pc_out unchanged, misalign_err=1 for one cycle, bad_addr=0x102; same target with IALIGN=16 accepted, pc_out=0x102.
REQ-038 IALIGN=16, pc_out=0x10, inst_is_c=1 then 0 -> pc_out 0x12 then 0x16; pc_out=0xFFFF_FFFC, step 4 -> 0x0000_0000.
REQ-039 halt_req=1 at pc_out=0x40 -> fetch_valid=0, pc holds 0x40 while halted; halt_req=0 -> fetch_valid=1, advances to 0x44; rst asserted during HALT -> BOOT, pc_out=RESET_ADDR.
